// File: rtl/cache_fill_ctrl_if.sv
// Bus bundle between the miss/fill controller and its three neighbours:
// the CPU memory-stage port, the fully associative CACHE and line-wide memory.
//
//   master : controller view (drives CPU response, CACHE controls, memory request)
//   slave  : environment view (CPU request, CACHE lookup result, memory response)
//
// CPU    : cpu_req_valid/cpu_req_write/cpu_addr/cpu_wdata in, cpu_rdata/cpu_stall out
// CACHE  : cache_addr/cache_line/cache_readC/cache_writeC/cache_writeCword out,
//          cache_rdata/cache_hit in (cache_hit is combinational on cache_addr)
// Memory : mem_req/mem_write/mem_addr/mem_wdata out, mem_rdata/mem_ready in
interface cache_fill_ctrl_if #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned LINE_SIZE = 64
);
  logic                 cpu_req_valid;
  logic                 cpu_req_write;
  logic [WORD_SIZE-1:0] cpu_addr;
  logic [WORD_SIZE-1:0] cpu_wdata;
  logic [WORD_SIZE-1:0] cpu_rdata;
  logic                 cpu_stall;

  logic [WORD_SIZE-1:0] cache_addr;
  logic [LINE_SIZE-1:0] cache_line;
  logic                 cache_readC;
  logic                 cache_writeC;
  logic                 cache_writeCword;
  logic [WORD_SIZE-1:0] cache_rdata;
  logic                 cache_hit;

  logic                 mem_req;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [LINE_SIZE-1:0] mem_rdata;
  logic                 mem_ready;

  modport master (
    input  cpu_req_valid, cpu_req_write, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    output cache_addr, cache_line, cache_readC, cache_writeC, cache_writeCword,
    input  cache_rdata, cache_hit,
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output cpu_req_valid, cpu_req_write, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    input  cache_addr, cache_line, cache_readC, cache_writeC, cache_writeCword,
    output cache_rdata, cache_hit,
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Miss/fill controller for a fully associative cache in front of line-wide memory.
// Read misses fetch the 4-word line, install it in one cycle and replay the lookup.
// Stores are write-through / no-write-allocate: memory is always written, the cache
// word only when the store hit. The CPU is stalled for every miss and every store.
//
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   bus           : cache_fill_ctrl_if.master (CPU, CACHE and memory signals)
//   hit_count     : saturating count of completed accesses that hit
//   access_count  : saturating count of completed accesses
module cache_fill_ctrl #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned LINE_SIZE = 64,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cache_fill_ctrl_if.master    bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] access_count
);

  typedef enum logic [1:0] {StIdle, StFillWait, StFillWrite, StWbWait} state_e;

  state_e               state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_write_q, mem_write_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_SIZE-1:0] line_q, line_d;
  logic                 filled_q, filled_d;
  logic                 wr_hit_q, wr_hit_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;

  logic [WORD_SIZE-1:0] line_base;
  logic                 stall_c;
  logic                 complete;
  logic                 count_hit;

  logic                 readc_c, writec_c, writecword_c;
  logic [WORD_SIZE-1:0] cache_addr_c;
  logic [LINE_SIZE-1:0] cache_line_c;

  assign line_base = {bus.cpu_addr[WORD_SIZE-1:2], 2'b00};

  // CACHE controls. Kept apart from the next-state logic because cache_hit is a
  // combinational function of cache_addr; nothing here may depend on cache_hit.
  always_comb begin
    readc_c      = 1'b0;
    writec_c     = 1'b0;
    writecword_c = 1'b0;
    cache_addr_c = '0;
    cache_line_c = '0;
    if (reset_n) begin
      case (state_q)
        StIdle: begin
          if (bus.cpu_req_valid) begin
            readc_c      = 1'b1;
            cache_addr_c = bus.cpu_addr;
          end
        end
        StFillWrite: begin
          writec_c     = 1'b1;
          cache_addr_c = line_base;
          cache_line_c = line_q;
        end
        StWbWait: begin
          // Store hit: update the resident word in the same cycle memory acknowledges.
          if (bus.mem_ready && wr_hit_q) begin
            writec_c     = 1'b1;
            writecword_c = 1'b1;
            cache_addr_c = bus.cpu_addr;
            cache_line_c = {mem_wdata_q, {(LINE_SIZE-WORD_SIZE){1'b0}}};
          end
        end
        default: ;
      endcase
    end
  end

  // Next state, stall and statistics.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    line_d      = line_q;
    filled_d    = filled_q;
    wr_hit_d    = wr_hit_q;
    hit_cnt_d   = hit_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    stall_c     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.cpu_req_valid) begin
          if (!bus.cpu_req_write) begin
            if (!bus.cache_hit) begin
              stall_c     = 1'b1;
              state_d     = StFillWait;
              mem_req_d   = 1'b1;
              mem_write_d = 1'b0;
              mem_addr_d  = line_base;
            end
          end else begin
            stall_c     = 1'b1;
            wr_hit_d    = bus.cache_hit;
            state_d     = StWbWait;
            mem_req_d   = 1'b1;
            mem_write_d = 1'b1;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
          end
        end
      end
      StFillWait: begin
        stall_c = 1'b1;
        if (bus.mem_ready) begin
          line_d    = bus.mem_rdata;
          mem_req_d = 1'b0;
          state_d   = StFillWrite;
        end
      end
      StFillWrite: begin
        stall_c  = 1'b1;
        filled_d = 1'b1; // the replayed lookup hits but is not counted as a hit
        state_d  = StIdle;
      end
      StWbWait: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    complete  = bus.cpu_req_valid && !stall_c;
    count_hit = bus.cpu_req_write ? wr_hit_q : !filled_q;
    if (complete) begin
      filled_d = 1'b0;
      if (acc_cnt_q != '1) acc_cnt_d = acc_cnt_q + 1'b1;
      if (count_hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      line_q      <= '0;
      filled_q    <= 1'b0;
      wr_hit_q    <= 1'b0;
      hit_cnt_q   <= '0;
      acc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      line_q      <= line_d;
      filled_q    <= filled_d;
      wr_hit_q    <= wr_hit_d;
      hit_cnt_q   <= hit_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
    end
  end

  assign bus.cache_readC      = readc_c;
  assign bus.cache_writeC     = writec_c;
  assign bus.cache_writeCword = writecword_c;
  assign bus.cache_addr       = cache_addr_c;
  assign bus.cache_line       = cache_line_c;
  assign bus.cpu_stall        = reset_n && stall_c;
  assign bus.cpu_rdata        = reset_n ? bus.cache_rdata : '0;
  assign bus.mem_req          = mem_req_q;
  assign bus.mem_write        = mem_write_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_wdata        = mem_wdata_q;
  assign hit_count            = hit_cnt_q;
  assign access_count         = acc_cnt_q;

endmodule
